// File: rtl/nco_pkg.sv
// Shared types and constants for the multi-channel NCO phase accumulator.
// Holds the config register select codes, the per-channel sweep states and
// the dither LFSR constants used when NCO_PHASE_DITHER_EN is defined.
package nco_pkg;

   typedef enum logic [1:0] {
      FREQ   = 2'd0,
      OFFSET = 2'd1,
      STEP   = 2'd2,
      LIMIT  = 2'd3
   } cfg_sel_e;

   typedef enum logic [1:0] {
      STATIC   = 2'd0,
      SWEEPING = 2'd1,
      DONE     = 2'd2
   } sweep_state_e;

   // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
   localparam logic [15:0] LFSR_POLY = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: shadow and active config registers, the phase
// accumulator, the registered phase output and the linear sweep FSM.
// The dither input is an already-aligned value added before truncation;
// it is tied to zero by the top when dithering is not built in.
module nco_channel
   import nco_pkg::*;
#(
   parameter int width     = 26,
   parameter int out_width = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 wr_en,
   input  cfg_sel_e             wr_sel,
   input  logic [width-1:0]     wr_data,
   input  logic                 update,
   input  logic                 sync_clear,
   input  logic [width-1:0]     dither,
   output logic [out_width-1:0] phase,
   output logic                 wrap,
   output logic                 sweep_done
);

   logic [width-1:0] freq_sh;
   logic [width-1:0] offset_sh;
   logic [width-1:0] step_sh;
   logic [width-1:0] limit_sh;

   logic [width-1:0] inc;
   logic [width-1:0] offset;
   logic [width-1:0] step;
   logic [width-1:0] limit;
   sweep_state_e     state;

   logic [width-1:0] acc;
   logic [width:0]   acc_sum;
   logic [width:0]   sweep_sum;
   logic [width-1:0] phase_sum;

   assign acc_sum    = {1'b0, acc} + {1'b0, inc};
   assign sweep_sum  = {1'b0, inc} + {1'b0, step};
   assign phase_sum  = acc + offset + dither;
   assign sweep_done = (state == DONE);

   // Shadow registers take accepted config writes addressed to this channel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         freq_sh   <= '0;
         offset_sh <= '0;
         step_sh   <= '0;
         limit_sh  <= '0;
      end else if (wr_en) begin
         case (wr_sel)
            FREQ:    freq_sh   <= wr_data;
            OFFSET:  offset_sh <= wr_data;
            STEP:    step_sh   <= wr_data;
            default: limit_sh  <= wr_data;
         endcase
      end
   end

   // Commit copies shadow to active and restarts the sweep; otherwise a
   // running sweep steps inc towards limit, clamping on reach or overflow
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inc    <= '0;
         offset <= '0;
         step   <= '0;
         limit  <= '0;
         state  <= STATIC;
      end else if (update) begin
         inc    <= freq_sh;
         offset <= offset_sh;
         step   <= step_sh;
         limit  <= limit_sh;
         state  <= ((step_sh != '0) && (freq_sh < limit_sh)) ? SWEEPING : STATIC;
      end else if ((state == SWEEPING) && enable) begin
         if (sweep_sum >= {1'b0, limit}) begin
            inc   <= limit;
            state <= DONE;
         end else begin
            inc   <= sweep_sum[width-1:0];
         end
      end
   end

   // Phase accumulator with carry-out pulse; sync_clear overrides enable
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc  <= '0;
         wrap <= 1'b0;
      end else if (sync_clear) begin
         acc  <= '0;
         wrap <= 1'b0;
      end else if (enable) begin
         acc  <= acc_sum[width-1:0];
         wrap <= acc_sum[width];
      end else begin
         wrap <= 1'b0;
      end
   end

   // Registered truncated phase of the offset (and optionally dithered) accumulator
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= '0;
      end else begin
         phase <= phase_sum[width-1 -: out_width];
      end
   end

endmodule

// File: rtl/nco_phase_accumulator_mc.sv
// Multi-channel NCO phase accumulator top level. Decodes config writes to
// the per-channel shadow registers, generates cfg_ready, and instantiates
// num_channels independent nco_channel blocks.
// Optional: define NCO_PHASE_DITHER_EN to add a shared 16-bit LFSR whose
// per-channel rotated low bits dither the phase before truncation.
module nco_phase_accumulator_mc
   import nco_pkg::*;
#(
   parameter int width        = 26,
   parameter int out_width    = 12,
   parameter int num_channels = 4,
   localparam int CHAN_W      = (num_channels > 1) ? $clog2(num_channels) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              enable,
   input  logic                              cfg_valid,
   output logic                              cfg_ready,
   input  logic [CHAN_W-1:0]                 cfg_chan,
   input  logic [1:0]                        cfg_sel,
   input  logic [width-1:0]                  cfg_data,
   input  logic                              update,
   input  logic [num_channels-1:0]           sync_clear,
   output logic [num_channels*out_width-1:0] phase_out,
   output logic [num_channels-1:0]           wrap,
   output logic [num_channels-1:0]           sweep_done
);

   logic cfg_fire;

   assign cfg_ready = !update;
   assign cfg_fire  = cfg_valid && cfg_ready;

`ifdef NCO_PHASE_DITHER_EN
   localparam int DW = ((width - out_width) < 16) ? (width - out_width) : 16;

   logic [15:0] lfsr;

   // Shared Galois LFSR, advancing only on cycles the accumulators advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr <= LFSR_SEED;
      end else if (enable) begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
      end
   end
`endif

   for (genvar i = 0; i < num_channels; i++) begin : g_chan
      logic             wr_en;
      logic [width-1:0] dither;

      assign wr_en = cfg_fire && (cfg_chan == CHAN_W'(i));

`ifdef NCO_PHASE_DITHER_EN
      localparam int ROT = i % 16;
      logic [31:0] lfsr_dbl;
      logic [15:0] lfsr_rot;

      assign lfsr_dbl = {lfsr, lfsr};
      assign lfsr_rot = lfsr_dbl[16-ROT +: 16];

      // Low bits of this channel's rotated LFSR, zero-extended to width
      always_comb begin
         dither         = '0;
         dither[DW-1:0] = lfsr_rot[DW-1:0];
      end
`else
      assign dither = '0;
`endif

      nco_channel #(
         .width     (width),
         .out_width (out_width)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .enable     (enable),
         .wr_en      (wr_en),
         .wr_sel     (cfg_sel_e'(cfg_sel)),
         .wr_data    (cfg_data),
         .update     (update),
         .sync_clear (sync_clear[i]),
         .dither     (dither),
         .phase      (phase_out[i*out_width +: out_width]),
         .wrap       (wrap[i]),
         .sweep_done (sweep_done[i])
      );
   end

endmodule

// File: tb/tb_nco_phase_accumulator_mc.sv
// Self-checking bench for nco_phase_accumulator_mc (default build, no dither).
// Three channels are used so that cfg_chan = 3 addresses a missing channel.
// A cycle-level arithmetic model of the channels is compared with the DUT
// after every rising edge; directed literal checks pin the model.
module tb_nco_phase_accumulator_mc;

   localparam int W  = 26;
   localparam int OW = 12;
   localparam int NC = 3;
   localparam int CW = 2;
   localparam longint unsigned MASK = (64'd1 << W) - 1;

   logic             clk;
   logic             reset;
   logic             enable;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CW-1:0]    cfg_chan;
   logic [1:0]       cfg_sel;
   logic [W-1:0]     cfg_data;
   logic             update;
   logic [NC-1:0]    sync_clear;
   logic [NC*OW-1:0] phase_out;
   logic [NC-1:0]    wrap;
   logic [NC-1:0]    sweep_done;

   int n_cmp  = 0;
   int n_fail = 0;

   nco_phase_accumulator_mc #(
      .width        (W),
      .out_width    (OW),
      .num_channels (NC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_chan   (cfg_chan),
      .cfg_sel    (cfg_sel),
      .cfg_data   (cfg_data),
      .update     (update),
      .sync_clear (sync_clear),
      .phase_out  (phase_out),
      .wrap       (wrap),
      .sweep_done (sweep_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint unsigned got, input longint unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Behavioural model state: shadow[ch][sel], active registers, accumulator
   longint unsigned m_sh [NC][4];
   longint unsigned m_inc [NC];
   longint unsigned m_off [NC];
   longint unsigned m_stp [NC];
   longint unsigned m_lim [NC];
   longint unsigned m_acc [NC];
   longint unsigned m_phase [NC];
   bit              m_wrap [NC];
   bit              m_sweeping [NC];
   bit              m_done [NC];
   longint unsigned s, nacc, nph;
   bit              nwrap;

   // Advance the model on each rising edge, then compare once the DUT settles
   always @(posedge clk) begin
      for (int ch = 0; ch < NC; ch++) begin
         if (reset) begin
            for (int r = 0; r < 4; r++) m_sh[ch][r] = 0;
            m_inc[ch] = 0; m_off[ch] = 0; m_stp[ch] = 0; m_lim[ch] = 0;
            m_acc[ch] = 0; m_phase[ch] = 0; m_wrap[ch] = 0;
            m_sweeping[ch] = 0; m_done[ch] = 0;
         end else begin
            nph = ((m_acc[ch] + m_off[ch]) & MASK) >> (W - OW);
            if (sync_clear[ch]) begin
               nacc = 0; nwrap = 0;
            end else if (enable) begin
               s = m_acc[ch] + m_inc[ch];
               nwrap = (s >> W) != 0;
               nacc = s & MASK;
            end else begin
               nacc = m_acc[ch]; nwrap = 0;
            end
            if (update) begin
               m_inc[ch] = m_sh[ch][0];
               m_off[ch] = m_sh[ch][1];
               m_stp[ch] = m_sh[ch][2];
               m_lim[ch] = m_sh[ch][3];
               m_done[ch] = 0;
               m_sweeping[ch] = (m_stp[ch] != 0) && (m_inc[ch] < m_lim[ch]);
            end else if (m_sweeping[ch] && enable) begin
               s = m_inc[ch] + m_stp[ch];
               if (s >= m_lim[ch]) begin
                  m_inc[ch] = m_lim[ch];
                  m_sweeping[ch] = 0;
                  m_done[ch] = 1;
               end else begin
                  m_inc[ch] = s;
               end
            end
            m_acc[ch] = nacc; m_wrap[ch] = nwrap; m_phase[ch] = nph;
            if (cfg_valid && !update && (int'(cfg_chan) == ch))
               m_sh[ch][cfg_sel] = cfg_data;
         end
      end
      #1;
      for (int ch = 0; ch < NC; ch++) begin
         checkOutput($sformatf("phase ch%0d", ch), phase_out[ch*OW +: OW], m_phase[ch]);
         checkOutput($sformatf("wrap ch%0d", ch), wrap[ch], m_wrap[ch]);
         checkOutput($sformatf("sweep_done ch%0d", ch), sweep_done[ch], m_done[ch]);
      end
      checkOutput("cfg_ready", cfg_ready, !update);
   end

   task automatic applyStimulus(input bit v, input logic [CW-1:0] ch, input logic [1:0] sel,
                                input logic [W-1:0] d, input bit upd, input logic [NC-1:0] sc,
                                input bit en);
      cfg_valid = v; cfg_chan = ch; cfg_sel = sel; cfg_data = d;
      update = upd; sync_clear = sc; enable = en;
      @(negedge clk);
   endtask

   task automatic writeCfg(input logic [CW-1:0] ch, input logic [1:0] sel, input logic [W-1:0] d);
      applyStimulus(1'b1, ch, sel, d, 1'b0, '0, 1'b0);
   endtask

   task automatic idle(input bit en, input int n);
      repeat (n) applyStimulus(1'b0, '0, 2'd0, '0, 1'b0, '0, en);
   endtask

   int          wrap0_cnt;
   int          wrap1_cnt;
   logic [11:0] prev0;
   logic [11:0] cur0;

   initial begin
      reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_chan = '0;
      cfg_sel = '0; cfg_data = '0; update = 1'b0; sync_clear = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset phase_out", phase_out, 0);
      checkOutput("reset wrap", wrap, 0);
      checkOutput("reset sweep_done", sweep_done, 0);
      reset = 1'b0;

      writeCfg(2'd0, 2'd0, 26'h0100000);
      writeCfg(2'd1, 2'd1, 26'h2000000);
      writeCfg(2'd2, 2'd0, 26'h0001000);
      writeCfg(2'd2, 2'd2, 26'h0001000);
      writeCfg(2'd2, 2'd3, 26'h0005000);
      writeCfg(2'd3, 2'd0, 26'h3FFFFFF);
      applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0, 1'b0);
      idle(1'b0, 1);
      checkOutput("ch1 offset phase", phase_out[OW +: OW], 12'h800);
      checkOutput("ch0 idle phase", phase_out[0 +: OW], 0);

      wrap0_cnt = 0; wrap1_cnt = 0;
      idle(1'b1, 2);
      wrap0_cnt += wrap[0]; wrap1_cnt += wrap[1];
      idle(1'b0, 2);
      checkOutput("ch2 frozen sweep", sweep_done[2], 0);
      idle(1'b1, 1);
      wrap0_cnt += wrap[0];
      checkOutput("ch2 sweep at 0x4000", sweep_done[2], 0);
      idle(1'b1, 1);
      wrap0_cnt += wrap[0];
      checkOutput("ch2 sweep reached limit", sweep_done[2], 1);

      prev0 = phase_out[0 +: OW];
      for (int i = 0; i < 66; i++) begin
         idle(1'b1, 1);
         wrap0_cnt += wrap[0]; wrap1_cnt += wrap[1];
         cur0 = phase_out[0 +: OW];
         if (i >= 2 && (i % 16) == 0) checkOutput("ch0 phase step", 12'(cur0 - prev0), 64);
         prev0 = cur0;
      end
      checkOutput("ch0 wrap count over 70 cycles", wrap0_cnt, 1);
      checkOutput("ch1 wrap count", wrap1_cnt, 0);
      checkOutput("ch2 done holds", sweep_done[2], 1);

      cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_sel = 2'd0; cfg_data = 26'h0200000;
      update = 1'b1; sync_clear = '0; enable = 1'b1;
      #1 checkOutput("cfg_ready with update", cfg_ready, 0);
      @(negedge clk);
      applyStimulus(1'b1, 2'd0, 2'd0, 26'h0200000, 1'b0, '0, 1'b1);
      idle(1'b1, 3);
      prev0 = phase_out[0 +: OW];
      idle(1'b1, 1);
      checkOutput("ch0 still old freq", 12'(phase_out[0 +: OW] - prev0), 64);
      applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, 3'b001, 1'b1);
      idle(1'b1, 1);
      checkOutput("ch0 cleared phase", phase_out[0 +: OW], 0);
      idle(1'b1, 1);
      checkOutput("ch0 new freq phase", phase_out[0 +: OW], 128);
      checkOutput("ch1 unaffected", phase_out[OW +: OW], 12'h800);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 2) == 0), CW'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       W'($urandom), ($urandom_range(0, 19) == 0),
                       {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)},
                       ($urandom_range(0, 3) != 0));
      end

      writeCfg(2'd0, 2'd0, 26'h0123456);
      writeCfg(2'd2, 2'd0, 26'h0000100);
      writeCfg(2'd2, 2'd2, 26'h0000010);
      writeCfg(2'd2, 2'd3, 26'h3000000);
      applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0, 1'b1);
      idle(1'b1, 3);
      #2 reset = 1'b1;
      #1;
      checkOutput("async reset phase_out", phase_out, 0);
      checkOutput("async reset wrap", wrap, 0);
      checkOutput("async reset sweep_done", sweep_done, 0);
      @(negedge clk);
      reset = 1'b0;
      idle(1'b1, 10);
      checkOutput("post-reset no movement", phase_out, 0);
      checkOutput("post-reset sweep_done", sweep_done, 0);

      idle(1'b0, 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/nco_phase_accumulator_mc.md
Name: nco_phase_accumulator_mc

Overview:
Multi-channel, parametrised phase accumulator for the NCO datapath. It is the successor to the single-channel accumulator.
- Runs num_channels independent accumulators.
- Per-channel frequency, phase-offset and linear frequency-sweep (chirp) registers, double-buffered behind a config handshake and a global commit strobe.
- Feeds truncated phase words to the downstream sine LUT stage.

Parameters:
width, 26, accumulator / frequency-word width in bits
out_width, 12, phase output width (top bits of accumulator); must satisfy 1 <= out_width < width
num_channels, 4, number of independent channels (>= 1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
enable  input  1  global advance; when low, accumulators and sweeps hold
cfg_valid  input  1  config write request
cfg_ready  output  1  config write accept
cfg_chan  input  $clog2(num_channels) (min 1)  target channel
cfg_sel  input  2  register select: 0 FREQ, 1 OFFSET, 2 STEP, 3 LIMIT
cfg_data  input  width  write data
update  input  1  commit all shadow registers to active, all channels simultaneously
sync_clear  input  num_channels  per-channel phase zero
phase_out  output  num_channels*out_width  channel i in bits [i*out_width +: out_width]
wrap  output  num_channels  one-cycle pulse on accumulator carry-out
sweep_done  output  num_channels  level; channel sweep reached LIMIT

Behaviour:
- Reset (async, immediate): all shadow and active registers = 0, accumulators = 0, phase_out = 0, wrap = 0, sweep_done = 0, sweep FSMs = STATIC. cfg_ready is combinational and not reset-dependent.
- Config handshake:
  - Write occurs when cfg_valid && cfg_ready; it updates shadow[cfg_chan][cfg_sel] at the next edge.
  - cfg_ready = !update (combinational). A write coinciding with update is not accepted; the master holds it.
  - cfg_chan >= num_channels: write accepted and discarded.
- Commit: on update, every channel copies shadow to active (inc <= FREQ, offset, step, limit) and clears sweep_done.
  - Sweep FSM goes to SWEEPING if STEP != 0 && FREQ < LIMIT; otherwise STATIC.
- Accumulator, per channel, each edge:
  - If sync_clear[i]: acc <= 0, wrap <= 0 (highest priority, independent of enable).
  - Else if enable: {carry, acc} <= acc + inc (unsigned, natural mod 2^width wrap); wrap[i] <= carry.
  - Else: hold, wrap <= 0.
  - The increment used is the active inc before any same-cycle commit or sweep step.
- Phase output: phase_out[i] <= upper out_width bits of (acc + offset) mod 2^width.
  - Registered; latency 1 cycle from acc, so 2 cycles from the increment edge.
  - Offset changes do not disturb acc.
- Sweep FSM (per channel): STATIC, SWEEPING, DONE.
  - STATIC: inc constant.
  - SWEEPING, enable high: sum = inc + step (width+1 bits).
    - If sum >= limit (including overflow): inc <= limit, go to DONE.
    - Else inc <= sum.
  - SWEEPING, enable low: hold.
  - DONE: sweep_done = 1, inc holds limit until the next update.
  - sync_clear does not affect the sweep FSM.
- Simultaneous events:
  - update with sync_clear: acc cleared, config committed.
  - update during SWEEPING: restart from the new FREQ.

Optional Feature:
Macro NCO_PHASE_DITHER_EN.
- Defined: one shared 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every enable cycle.
  - Its low (width-out_width) bits, zero-extended if fewer than 16, are added to (acc + offset) before truncation.
  - Channel i uses the LFSR rotated by i bits.
- Undefined: plain truncation, no LFSR logic.

Decomposition:
- Package nco_pkg:
  - cfg_sel_e enum (FREQ, OFFSET, STEP, LIMIT)
  - sweep_state_e enum (STATIC, SWEEPING, DONE)
  - LFSR polynomial and seed constants
- Sub-module nco_channel:
  - one accumulator, its shadow/active registers and sweep FSM
  - instantiated num_channels times via generate
- Top level holds the config decode, the cfg_ready logic and the optional LFSR.

Test Plan:
- ch0 FREQ=26'h0100000, update, enable=1 -> phase_out[ch0] increments by 64 per cycle; wrap[0] pulses every 64 cycles.
- ch1 FREQ=0, OFFSET=26'h2000000, update -> phase_out[ch1]=12'h800 two cycles later; acc stays 0, wrap[1] never pulses.
- ch2 FREQ=0x1000, STEP=0x1000, LIMIT=0x5000, update, enable=1 -> inc 0x2000, 0x3000, 0x4000, 0x5000 on successive cycles; then sweep_done[2]=1 and inc holds 0x5000. enable low mid-sweep freezes inc.
- cfg_valid asserted in the same cycle as update -> cfg_ready=0, shadow unchanged; write lands the next cycle, and active registers take it only at the next update.
- sync_clear[0] and update in the same cycle during a run -> acc0=0 the next edge, new config active; other channels unaffected.
- reset asserted mid-sweep, between clock edges -> all outputs 0 immediately, without waiting for a clock edge; after release, FREQ=0 and no phase movement until a new config is written and committed.
